// File: rtl/iqueue_mw.sv
// iqueue_mw: halfword circular instruction queue issuing up to DECODE_W RVC/RVI instructions per cycle.
// Define IQ_PERF_EN to add saturating empty/full cycle counters.
module iqueue_mw #(
  parameter int FETCH_HW = 4,
  parameter int BUF_HW   = 16,
  parameter int DECODE_W = 2
) (
  input  logic                          CLK,
  input  logic                          RSTn,
  input  logic                          flush,
  input  logic                          if_iq_valid,
  output logic                          if_iq_ready,
  input  logic [63:0]                   if_iq_pc,
  input  logic [16*FETCH_HW-1:0]        if_iq_instr,
  input  logic [FETCH_HW-1:0]           if_iq_mask,
  output logic [DECODE_W-1:0]           iq_id_valid,
  output logic [97*DECODE_W-1:0]        iq_id_info,
  input  logic                          iq_id_ready,
  output logic [$clog2(BUF_HW+1)-1:0]   iq_count
`ifdef IQ_PERF_EN
  ,
  output logic [63:0]                   iq_empty_cycles,
  output logic [63:0]                   iq_full_cycles
`endif
);
  localparam int PW = $clog2(BUF_HW);
  localparam int CW = $clog2(BUF_HW+1);
  localparam int OW = CW + 4;
  logic [15:0]   mem [BUF_HW];
  logic [PW-1:0] rd_ptr, wr_ptr, idx;
  logic [CW-1:0] occ, push_hw, pop_hw;
  logic [OW-1:0] off, sz;
  logic [63:0]   head_pc;
  logic [15:0]   lo, hi;
  logic          push, pop, ok, rvi, fit;

  assign if_iq_ready = occ <= CW'(BUF_HW - FETCH_HW);
  assign push        = if_iq_valid & if_iq_ready & ~flush;
  assign pop         = iq_id_ready & ~flush;
  assign iq_count    = occ;

  always_comb begin
    push_hw = '0;
    for (int j = 0; j < FETCH_HW; j++) push_hw = push_hw + CW'(if_iq_mask[j]);
  end

  // Walk lanes from the head; each lane is valid only if all earlier lanes are and its halfwords are present.
  always_comb begin
    off = '0;
    ok = 1'b1;
    idx = '0;
    lo = '0;
    hi = '0;
    rvi = 1'b0;
    sz = '0;
    fit = 1'b0;
    iq_id_valid = '0;
    iq_id_info = '0;
    for (int i = 0; i < DECODE_W; i++) begin
      idx = rd_ptr + PW'(off);
      lo = mem[idx];
      hi = mem[idx + PW'(1)];
      rvi = &lo[1:0];
      sz = rvi ? OW'(2) : OW'(1);
      fit = ok && (off + sz <= OW'(occ));
      iq_id_valid[i] = fit & ~flush;
      iq_id_info[97*i +: 97] = {rvi ? {hi, lo} : {16'h0, lo}, head_pc + 64'({off, 1'b0}), ~rvi};
      off = fit ? off + sz : off;
      ok = fit;
    end
    pop_hw = pop ? CW'(off) : '0;
  end

  always_ff @(posedge CLK or negedge RSTn)
    if (!RSTn) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      occ     <= '0;
      head_pc <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      rd_ptr  <= rd_ptr + PW'(pop_hw);
      wr_ptr  <= wr_ptr + (push ? PW'(push_hw) : '0);
      occ     <= occ + (push ? push_hw : '0) - pop_hw;
      head_pc <= (push && occ == '0) ? if_iq_pc : head_pc + 64'({pop_hw, 1'b0});
    end

  always_ff @(posedge CLK)
    if (push)
      for (int j = 0; j < FETCH_HW; j++)
        if (if_iq_mask[j]) mem[wr_ptr + PW'(j)] <= if_iq_instr[16*j +: 16];

`ifdef IQ_PERF_EN
  always_ff @(posedge CLK or negedge RSTn)
    if (!RSTn) begin
      iq_empty_cycles <= '0;
      iq_full_cycles  <= '0;
    end else begin
      if (occ == '0 && !(&iq_empty_cycles)) iq_empty_cycles <= iq_empty_cycles + 64'd1;
      if (!if_iq_ready && !(&iq_full_cycles)) iq_full_cycles <= iq_full_cycles + 64'd1;
    end
`endif
endmodule

// File: doc/iqueue_mw.md
Name: iqueue_mw

Overview:
- Parametrised successor to the single-issue instruction queue.
- Buffers aligned fetch packets in a halfword-granular circular buffer and splits them into RVC/RVI instructions.
- Presents up to DECODE_W in-order instructions per cycle to the decoder.
- Sits between ifetch/iAlign and the decoder; branch prediction is outside this block, and any redirect arrives as flush.

Parameters:
FETCH_HW, 4, halfwords per fetch packet (fetch width = 16*FETCH_HW bits)
BUF_HW, 16, buffer depth in halfwords; power of two, >= 2*FETCH_HW
DECODE_W, 2, max instructions issued to decoder per cycle (1..4)

Ports:
CLK  in  1  clock
RSTn  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of queue contents
if_iq_valid  in  1  fetch packet valid
if_iq_ready  out  1  queue can accept a full packet
if_iq_pc  in  64  pc of halfword 0 of packet
if_iq_instr  in  16*FETCH_HW  aligned packet, halfword 0 in LSBs
if_iq_mask  in  FETCH_HW  valid halfwords, contiguous from bit 0
iq_id_valid  out  DECODE_W  per-lane valid, thermometer from lane 0
iq_id_info  out  97*DECODE_W  per lane {instr[31:0], pc[63:0], isRVC}; lane i at [97*i+96:97*i]
iq_id_ready  in  1  decoder accepts all asserted lanes this cycle
iq_count  out  $clog2(BUF_HW+1)  halfword occupancy

Behaviour:
- Reset (RSTn low, async): rd_ptr=0, wr_ptr=0, occ=0, head_pc=0. Outputs: if_iq_ready=1, iq_id_valid=0, iq_count=0. The contents of iq_id_info are don't-care.
- Storage: BUF_HW x 16-bit array. Pointers are log2(BUF_HW) bits and wrap modulo BUF_HW. Occupancy register occ tracks fill level.
- Push:
  - Occurs when if_iq_valid & if_iq_ready & ~flush.
  - Writes popcount(if_iq_mask) halfwords at wr_ptr, in order.
  - wr_ptr advances by that count.
  - A packet with if_iq_mask=0 is accepted with no effect.
- if_iq_ready = (BUF_HW - occ) >= FETCH_HW. It depends on registered state only; there is no path from iq_id_ready.
- head_pc:
  - When occ==0 at push, head_pc <= if_iq_pc.
  - Otherwise if_iq_pc is ignored; the fetcher guarantees sequential packets until flush.
- Lane decode (combinational from buffer head):
  - Lane 0 starts at rd_ptr with pc=head_pc.
  - A halfword with [1:0]!=2'b11 is RVC (size 1, instr={16'b0,hw}). Otherwise it is RVI (size 2, instr={hw+1,hw}).
  - Lane i starts at rd_ptr + sum(size of lanes <i), pc = head_pc + 2*that offset.
  - Lane i is valid iff lane i-1 is valid and its halfwords fit within occ.
  - An RVI with only its low halfword present is not valid; it waits for the next packet.
  - Halfword indices wrap modulo BUF_HW.
- Pop:
  - Occurs when iq_id_ready & ~flush.
  - pop_hw = total size of valid lanes; rd_ptr += pop_hw; head_pc += 2*pop_hw.
- Latency: a pushed halfword is visible on iq_id_* the cycle after acceptance. There is no bypass.
- Simultaneous push and pop: occ <= occ + push_hw - pop_hw. This is legal at any occupancy, including full-minus-FETCH_HW.
- Full: if_iq_ready=0, and pop still proceeds.
- Empty: iq_id_valid=0.
- Flush:
  - Priority over push and pop.
  - Next cycle: occ=0, rd_ptr=wr_ptr=0.
  - During the flush cycle iq_id_valid is forced to 0 combinationally, and the fetch packet presented that cycle is dropped.
- Reset mid-operation: all state returns to reset values immediately; contents are lost.
- Arithmetic: pc additions are 64-bit modulo 2^64. occ never exceeds BUF_HW, which is guaranteed by the ready rule.

Optional Feature:
- Macro IQ_PERF_EN.
- When defined:
  - Adds outputs iq_empty_cycles [63:0] and iq_full_cycles [63:0].
  - Each is a counter reset to 0 by RSTn and not cleared by flush.
  - iq_empty_cycles increments each cycle occ==0; iq_full_cycles increments each cycle if_iq_ready==0. Both saturate at all-ones.
- When undefined: the ports and logic are absent, and all other behaviour is identical.

Test Plan:
- Reset then one packet, pc=0x80000000, four RVI halfwords (0x0013,0x0000,0x0513,0x0000), mask=4'hF, iq_id_ready=1:
  - next cycle lane0={0x00000013,0x80000000,0}, lane1={0x00000513,0x80000004,0}, iq_id_valid=2'b11.
  - following cycle iq_count=0.
- Mixed packet RVC 0x4501, RVI 0x0093/0x0000, RVC 0x8082 at pc=0x1000:
  - lanes = {0x4501@0x1000,RVC} and {0x00000093@0x1002,RVI}.
  - next cycle lane0 = 0x8082@0x1006, iq_id_valid=2'b01.
- RVI split across packets: packet1 mask=4'b0001 holding low half 0x0513:
  - iq_id_valid=0.
  - packet2 supplies high half: lane0 instr=0x?????513 assembled, pc=packet1 pc.
- Fill with iq_id_ready=0: 4 packets accepted, iq_count=16, if_iq_ready=0, 5th packet held.
  - raise iq_id_ready: pop of 4 halfwords, ready returns next cycle; pointer wrap past index 15 gives correct order.
- flush asserted with occ=10 and if_iq_valid=1:
  - same cycle iq_id_valid=0; next cycle iq_count=0.
  - next packet pc=0x2000 sets head_pc=0x2000.
- IQ_PERF_EN defined, 5 idle cycles after reset then buffer full for 3 cycles: iq_empty_cycles=5 (plus any fill cycles at occ 0), iq_full_cycles=3.
